split_cand_scan: RTL and testbench
==================================

Name: split_cand_scan

Overview:
- Upstream stimulus stage for the split constraint checkers.
- Enumerates every assignment of the three shared checker operands (var_11, var_16, var_27) and presents each one to a combinational checker.
- Samples the checker's single satisfaction bit and buffers satisfying assignments in a small FIFO.
- Streams the buffered solutions downstream over a valid/ready interface. It counts hits and reports completion.

Parameters:
- W11, 4, width of var_11 candidate field
- W16, 4, width of var_16 candidate field
- W27, 7, width of var_27 candidate field
- FIFO_DEPTH, 4, solution buffer entries (power of two, >=2)
- HIT_LIMIT, 0, stop after this many hits; 0 = unlimited

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a scan (honoured only in IDLE or DONE)
- abort  in  1  pulse: stop scan, flush FIFO, return to IDLE
- cand_var_11  out  W11  candidate to checker
- cand_var_16  out  W16  candidate to checker
- cand_var_27  out  W27  candidate to checker
- sat_in  in  1  checker result for the current candidate (combinational, same cycle)
- sol_valid  out  1  FIFO head valid
- sol_ready  in  1  consumer accepts head
- sol_data  out  CW  packed solution {var_27,var_16,var_11}, CW=W11+W16+W27 (15)
- hit_count  out  16  satisfying candidates pushed this scan (saturates at 0xFFFF)
- busy  out  1  high in SCAN or DRAIN
- done  out  1  high in DONE

Behaviour:
- Reset values:
  - cnt = 0, so all cand_* = 0.
  - FIFO empty, so sol_valid = 0 and sol_data = 0.
  - hit_count = 0, busy = 0, done = 0, state = IDLE.
- cand_* are driven from a registered CW-bit counter cnt:
  - cnt[W11-1:0] -> var_11
  - next W16 bits -> var_16
  - top W27 bits -> var_27
  - sol_data uses the same packing.
- States IDLE, SCAN, DRAIN, DONE:
  - IDLE/DONE + start: cnt <= 0, hit_count <= 0, done <= 0, go to SCAN. The FIFO is already empty.
  - SCAN, each cycle, sat_in is evaluated against the current cnt:
    - sat_in=0: advance cnt.
    - sat_in=1 and FIFO not full: push cnt, hit_count++, advance.
    - sat_in=1 and FIFO full: stall. Hold cnt and do not push; re-evaluate next cycle.
  - SCAN exit conditions, both taking effect after any push:
    - Last candidate: when cnt is all-ones and the cycle advances (not stalled), go to DRAIN. cnt does not wrap to 0; it holds all-ones.
    - HIT_LIMIT != 0 and the push brings hit_count to HIT_LIMIT: go to DRAIN.
  - DRAIN: no pushes. When the FIFO is empty, go to DONE.
  - DONE: done=1 until the next start or abort.
- Any state + abort: FIFO flushed, sol_valid=0 next cycle, go to IDLE. hit_count holds its value; done clears. abort takes priority over start in the same cycle.
- start while busy: ignored.
- FIFO:
  - First-word fall-through; sol_valid/sol_data are registered.
  - A pushed entry appears at the head the cycle after the push when the FIFO was empty.
  - Pop on sol_valid & sol_ready.
  - Push is blocked when full, even if a pop occurs the same cycle. Full is computed on registered occupancy.
  - Simultaneous push and pop when not full: occupancy is unchanged and order is preserved.
- sol_data is stable while sol_valid=1 and sol_ready=0.
- Throughput: one candidate per cycle when there are no stalls. A full scan with no hits takes 2^CW SCAN cycles, then 1 DRAIN cycle, then DONE.
- Reset mid-scan: asynchronous clear to the reset values; pending solutions are discarded.

Decomposition:
- Shared package split_pkg holds:
  - the state enum (IDLE/SCAN/DRAIN/DONE)
  - the field widths (W11/W16/W27)
  - CW
  - the candidate packing/unpacking functions, so checkers and benches share one mapping.
- One natural sub-module: split_sol_fifo, a parameterised FWFT FIFO with async active-low reset, push/pop/full/empty and registered head.

Test Plan:
- sat_in tied 1, sol_ready tied 0, start:
  - FIFO fills with 0,1,2,3.
  - cnt stalls at 4 and hit_count=4.
  - Raising sol_ready yields 0,1,2,3,4,5... in order.
- sat_in tied 0, start:
  - No sol_valid.
  - busy for 32768 SCAN cycles + 1 DRAIN cycle, then done=1 with hit_count=0.
- Bench checker model sat = (var_11*var_16 truncated to 4 bits != 0) && var_27 != 0 && var_11 != 0x48, sol_ready=1:
  - Every emitted sol_data satisfies the model.
  - The emitted stream is strictly increasing.
  - hit_count equals the reference-model count.
- HIT_LIMIT=3, sat_in=1, sol_ready=1: exactly 3 solutions (0,1,2), then DRAIN, then done=1.
- Mid-scan abort with FIFO holding 2 entries: next cycle sol_valid=0, busy=0, done=0; a following start restarts at cnt=0.
- rst_n low mid-scan: all outputs take their reset values immediately, without waiting for a clock edge. start issued while busy causes no restart (cnt continues).

Source files
------------

// File: rtl/split_pkg.sv
// Shared definitions for the split constraint scanner: field widths,
// scan states and the one candidate packing used by checkers and benches.
package split_pkg;

   localparam int W11 = 4;
   localparam int W16 = 4;
   localparam int W27 = 7;
   localparam int CW  = W11 + W16 + W27;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_e;

   function automatic logic [CW-1:0] pack_cand(input logic [W11-1:0] v11,
                                               input logic [W16-1:0] v16,
                                               input logic [W27-1:0] v27);
      return {v27, v16, v11};
   endfunction

   function automatic logic [W11-1:0] cand_v11(input logic [CW-1:0] c);
      return c[W11-1:0];
   endfunction

   function automatic logic [W16-1:0] cand_v16(input logic [CW-1:0] c);
      return c[W11 +: W16];
   endfunction

   function automatic logic [W27-1:0] cand_v27(input logic [CW-1:0] c);
      return c[W11+W16 +: W27];
   endfunction

endpackage

// File: rtl/split_sol_fifo.sv
// First-word fall-through solution buffer. The head entry and its valid flag
// are registered; full/empty come from registered occupancy, so a push is
// refused when full even if the head is popped in the same cycle.
module split_sol_fifo #(
   parameter int DW    = 15,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic          head_valid,
   output logic [DW-1:0] head_data
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          head_valid_q, head_valid_d;
   logic [DW-1:0] head_data_q, head_data_d;
   logic          do_push, do_pop;

   assign full       = (count_q == (AW+1)'(DEPTH));
   assign empty      = (count_q == '0);
   assign do_push    = push & ~full & ~flush;
   assign do_pop     = pop & head_valid_q & ~flush;
   assign head_valid = head_valid_q;
   assign head_data  = head_data_q;

   // Next pointers/occupancy; the head register bypasses a push into an empty buffer.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
      head_valid_d = (count_d != '0);
      if (do_push && (wr_ptr_q == rd_ptr_d)) head_data_d = push_data;
      else                                   head_data_d = mem_q[rd_ptr_d];
   end

   // Storage array holds data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   // Pointer, occupancy and registered head state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_valid_q <= 1'b0;
         head_data_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_valid_q <= head_valid_d;
         head_data_q  <= head_data_d;
      end
   end

endmodule

// File: rtl/split_cand_scan.sv
// Candidate scanner: walks every {var_27,var_16,var_11} assignment, one per
// cycle, buffers the ones the external checker accepts and streams them out.
module split_cand_scan #(
   parameter int W11        = split_pkg::W11,
   parameter int W16        = split_pkg::W16,
   parameter int W27        = split_pkg::W27,
   parameter int FIFO_DEPTH = 4,
   parameter int HIT_LIMIT  = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   output logic [W11-1:0]         cand_var_11,
   output logic [W16-1:0]         cand_var_16,
   output logic [W27-1:0]         cand_var_27,
   input  logic                   sat_in,
   output logic                   sol_valid,
   input  logic                   sol_ready,
   output logic [W11+W16+W27-1:0] sol_data,
   output logic [15:0]            hit_count,
   output logic                   busy,
   output logic                   done
);
   import split_pkg::*;

   localparam int CAND_W = W11 + W16 + W27;
   localparam logic [CAND_W-1:0] CNT_LAST = '1;

   scan_state_e       state_q, state_d;
   logic [CAND_W-1:0] cnt_q, cnt_d;
   logic [15:0]       hit_q, hit_d;
   logic              fifo_push, fifo_flush, fifo_full, fifo_empty;

   assign cand_var_11 = cnt_q[W11-1:0];
   assign cand_var_16 = cnt_q[W11 +: W16];
   assign cand_var_27 = cnt_q[W11+W16 +: W27];
   assign hit_count   = hit_q;
   assign busy        = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
   assign done        = (state_q == ST_DONE);

   // Scan control: abort wins over everything; a stall holds cnt until the buffer frees.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hit_d      = hit_q;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      if (abort) begin
         fifo_flush = 1'b1;
         state_d    = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  cnt_d   = '0;
                  hit_d   = '0;
                  state_d = ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (!(sat_in && fifo_full)) begin
                  if (sat_in) begin
                     fifo_push = 1'b1;
                     if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
                     if ((HIT_LIMIT != 0) && (int'(hit_q) + 1 == HIT_LIMIT))
                        state_d = ST_DRAIN;
                  end
                  // The last candidate is not wrapped; cnt parks at all-ones.
                  if (cnt_q == CNT_LAST) state_d = ST_DRAIN;
                  else                   cnt_d   = cnt_q + CAND_W'(1);
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Scan state, candidate counter and hit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hit_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
      end
   end

   split_sol_fifo #(
      .DW    (CAND_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (fifo_flush),
      .push       (fifo_push),
      .push_data  (cnt_q),
      .pop        (sol_ready),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head_valid (sol_valid),
      .head_data  (sol_data)
   );

endmodule

// File: tb/tb_split_cand_scan.sv
// Bench for split_cand_scan: scenario tasks with inline checks against
// expectations derived from the scan rules (constants, a checker model,
// and a random satisfaction table).
`timescale 1ns/1ps
module tb_split_cand_scan;
   import split_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, sat_in, sol_ready;
   logic [3:0]  c11, c16;
   logic [6:0]  c27;
   logic        sol_valid, busy, done;
   logic [14:0] sol_data, cand;
   logic [15:0] hit_count;

   logic        start2, abort2, sat2, ready2;
   logic [3:0]  c11b, c16b;
   logic [6:0]  c27b;
   logic        sol_valid2, busy2, done2;
   logic [14:0] sol_data2;
   logic [15:0] hit_count2;

   int checks = 0;
   int errors = 0;
   int mode   = 0;
   bit sat_tab [1024];

   always #5 clk = ~clk;

   function automatic bit model_sat(input logic [14:0] c);
      int a, b, z;
      a = int'(cand_v11(c));
      b = int'(cand_v16(c));
      z = int'(cand_v27(c));
      return (((a * b) % 16) != 0) && (z != 0) && (a != 'h48);
   endfunction

   function automatic bit sat_rule(input int m, input logic [14:0] c);
      case (m)
         1:       return 1'b1;
         2:       return model_sat(c);
         3:       return (c < 15'd1024) ? sat_tab[c[9:0]] : 1'b0;
         default: return 1'b0;
      endcase
   endfunction

   assign cand   = pack_cand(c11, c16, c27);
   assign sat_in = sat_rule(mode, cand);

   split_cand_scan dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cand_var_11(c11), .cand_var_16(c16), .cand_var_27(c27),
      .sat_in(sat_in), .sol_valid(sol_valid), .sol_ready(sol_ready),
      .sol_data(sol_data), .hit_count(hit_count), .busy(busy), .done(done)
   );

   split_cand_scan #(.HIT_LIMIT(3)) u_lim (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
      .cand_var_11(c11b), .cand_var_16(c16b), .cand_var_27(c27b),
      .sat_in(sat2), .sol_valid(sol_valid2), .sol_ready(ready2),
      .sol_data(sol_data2), .hit_count(hit_count2), .busy(busy2), .done(done2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_reset();
      #23;
      checks++; if (cand !== 15'd0) begin errors++; $display("FAIL reset_cand: got %0d expected 0", cand); end
      checks++; if (sol_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sol_valid); end
      checks++; if (sol_data !== 15'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", sol_data); end
      checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL reset_hits: got %0d expected 0", hit_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done); end
   endtask

   task automatic test_hit_limit();
      logic [14:0] got[$];
      int cyc = 0;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      while (!done2 && cyc < 50) begin
         if (sol_valid2 && ready2) got.push_back(sol_data2);
         tick();
         cyc++;
      end
      checks++; if (got.size() != 3) begin errors++; $display("FAIL limit_count: got %0d expected 3", got.size()); end
      for (int i = 0; i < got.size() && i < 3; i++) begin
         checks++; if (got[i] !== 15'(i)) begin errors++; $display("FAIL limit_data[%0d]: got %0d expected %0d", i, got[i], i); end
      end
      checks++; if (hit_count2 !== 16'd3) begin errors++; $display("FAIL limit_hits: got %0d expected 3", hit_count2); end
      checks++; if (done2 !== 1'b1 || busy2 !== 1'b0) begin errors++; $display("FAIL limit_done: got done=%b busy=%b expected 1 0", done2, busy2); end
      checks++; if (pack_cand(c11b, c16b, c27b) !== 15'd3) begin errors++; $display("FAIL limit_cand: got %0d expected 3", pack_cand(c11b, c16b, c27b)); end
   endtask

   task automatic test_fill_stall();
      logic [15:0] h;
      mode = 1;
      sol_ready = 1'b0;
      pulse_start();
      repeat (8) tick();
      checks++; if (cand !== 15'd4) begin errors++; $display("FAIL stall_cand: got %0d expected 4", cand); end
      checks++; if (hit_count !== 16'd4) begin errors++; $display("FAIL stall_hits: got %0d expected 4", hit_count); end
      checks++; if (sol_valid !== 1'b1 || sol_data !== 15'd0) begin errors++; $display("FAIL stall_head: got valid=%b data=%0d expected 1 0", sol_valid, sol_data); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", busy); end
      sol_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (sol_valid !== 1'b1 || sol_data !== 15'(i)) begin errors++; $display("FAIL drain_order[%0d]: got valid=%b data=%0d expected 1 %0d", i, sol_valid, sol_data, i); end
         tick();
      end
      checks++; if (hit_count !== 16'(cand)) begin errors++; $display("FAIL all_hit_count: got %0d expected %0d", hit_count, cand); end
      h = hit_count;
      pulse_abort();
      checks++; if (sol_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state: got valid=%b busy=%b done=%b expected 0 0 0", sol_valid, busy, done); end
      checks++; if (hit_count !== h) begin errors++; $display("FAIL abort_hits_hold: got %0d expected %0d", hit_count, h); end
      sol_ready = 1'b0;
   endtask

   task automatic test_no_hits();
      int busy_cyc = 0, vld_seen = 0, cyc = 0;
      mode = 0;
      sol_ready = 1'b1;
      pulse_start();
      while (busy && cyc < 40000) begin
         busy_cyc++;
         if (sol_valid) vld_seen++;
         tick();
         cyc++;
      end
      checks++; if (busy_cyc != 32769) begin errors++; $display("FAIL nohit_busy_cycles: got %0d expected 32769", busy_cyc); end
      checks++; if (vld_seen != 0) begin errors++; $display("FAIL nohit_valid: got %0d expected 0", vld_seen); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL nohit_done: got %b expected 1", done); end
      checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL nohit_hits: got %0d expected 0", hit_count); end
      checks++; if (cand !== 15'h7FFF) begin errors++; $display("FAIL nohit_cand_hold: got %0d expected 32767", cand); end
   endtask

   task automatic test_model();
      int prev = -1, n = 0, cyc = 0, exp_n = 0;
      mode = 2;
      sol_ready = 1'b1;
      pulse_start();
      while (!done && cyc < 40000) begin
         if (sol_valid && sol_ready) begin
            checks++; if (model_sat(sol_data) !== 1'b1) begin errors++; $display("FAIL model_sat: got data %0d which model rejects, expected accepted", sol_data); end
            checks++; if (int'(sol_data) <= prev) begin errors++; $display("FAIL model_order: got %0d expected > %0d", sol_data, prev); end
            prev = int'(sol_data);
            n++;
         end
         tick();
         cyc++;
      end
      for (int v = 0; v < 32768; v++) if (model_sat(15'(v))) exp_n++;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL model_done: got %b expected 1", done); end
      checks++; if (hit_count !== 16'(exp_n)) begin errors++; $display("FAIL model_hits: got %0d expected %0d", hit_count, exp_n); end
      checks++; if (n != exp_n) begin errors++; $display("FAIL model_emitted: got %0d expected %0d", n, exp_n); end
   endtask

   task automatic test_random_table();
      logic [14:0] got[$];
      int          exp_list[$];
      int          ncyc, c0, c1;
      logic [14:0] d0;
      logic [15:0] h;
      for (int i = 0; i < 1024; i++) sat_tab[i] = ($urandom_range(0, 2) == 0);
      mode = 3;
      pulse_start();
      ncyc = $urandom_range(200, 400);
      for (int k = 0; k < ncyc; k++) begin
         sol_ready = ($urandom_range(0, 3) != 0);
         if (sol_valid && sol_ready) got.push_back(sol_data);
         tick();
      end
      sol_ready = 1'b0;
      c0 = int'(cand);
      for (int v = 0; v < c0; v++) if (sat_tab[v]) exp_list.push_back(v);
      checks++; if (hit_count !== 16'(exp_list.size())) begin errors++; $display("FAIL rand_hits: got %0d expected %0d", hit_count, exp_list.size()); end
      checks++; if (sol_valid !== (exp_list.size() != got.size())) begin errors++; $display("FAIL rand_occupancy: got valid=%b expected %b", sol_valid, exp_list.size() != got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (i >= exp_list.size() || int'(got[i]) != exp_list[i]) begin
            errors++;
            $display("FAIL rand_stream[%0d]: got %0d expected %0d", i, got[i], (i < exp_list.size()) ? exp_list[i] : -1);
         end
      end
      // Head must hold still under backpressure while the scan keeps going.
      d0 = sol_data;
      if (sol_valid) begin
         repeat (3) tick();
         checks++; if (sol_valid !== 1'b1 || sol_data !== d0) begin errors++; $display("FAIL hold_head: got valid=%b data=%0d expected 1 %0d", sol_valid, sol_data, d0); end
      end
      c1 = int'(cand);
      pulse_start();
      checks++; if (busy !== 1'b1 || int'(cand) < c1) begin errors++; $display("FAIL start_while_busy: got busy=%b cand=%0d expected 1 and cand>=%0d", busy, cand, c1); end
      repeat (4) tick();
      h = hit_count;
      pulse_abort();
      checks++; if (sol_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rand_abort: got valid=%b busy=%b done=%b expected 0 0 0", sol_valid, busy, done); end
      checks++; if (hit_count !== h) begin errors++; $display("FAIL rand_abort_hits: got %0d expected %0d", hit_count, h); end
      pulse_start();
      checks++; if (cand !== 15'd0 || hit_count !== 16'd0 || busy !== 1'b1) begin errors++; $display("FAIL restart: got cand=%0d hits=%0d busy=%b expected 0 0 1", cand, hit_count, busy); end
      pulse_abort();
   endtask

   task automatic test_reset_midscan();
      mode = 1;
      sol_ready = 1'b0;
      pulse_start();
      repeat (10) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (cand !== 15'd0) begin errors++; $display("FAIL arst_cand: got %0d expected 0", cand); end
      checks++; if (sol_valid !== 1'b0 || sol_data !== 15'd0) begin errors++; $display("FAIL arst_fifo: got valid=%b data=%0d expected 0 0", sol_valid, sol_data); end
      checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL arst_hits: got %0d expected 0", hit_count); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_state: got busy=%b done=%b expected 0 0", busy, done); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      sol_ready = 1'b0;
      start2    = 1'b0;
      abort2    = 1'b0;
      sat2      = 1'b1;
      ready2    = 1'b1;
      test_reset();
      test_hit_limit();
      test_fill_stall();
      test_no_hits();
      test_model();
      test_random_table();
      test_reset_midscan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
